// File: rtl/uart_tx_sequencer_pkg.sv
// Shared state encodings, parity-type constants and parameter defaults
// for the UART transmit sequencer.
package uart_tx_sequencer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PRESCALE_W_DEF = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_tx_sequencer_parity_calc.sv
// Combinational parity of a data word; even or odd selected by par_odd.
module uart_parity_calc
    import uart_tx_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_odd,
    output logic                  parity_c
);

    logic data_xor;

    assign data_xor = ^data;

    always_comb begin
        parity_c = data_xor;
        case (par_odd)
            PAR_EVEN: parity_c = data_xor;
            PAR_ODD:  parity_c = ~data_xor;
            default:  parity_c = data_xor;
        endcase
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART frame transmitter: start, LSB-first data, optional parity, one or two
// stop bits; each bit lasts a programmable number of clocks.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_en,
    input  logic                  i_par_odd,
    input  logic                  i_stop2,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

    tx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_q, stop2_q;
    logic [PRESCALE_W-1:0] pre_q;

    logic                  load;
    logic                  tick;
    logic                  tx_d, busy_d, done_d;
    logic                  parity_c;
    logic [PRESCALE_W-1:0] reload_q_c, reload_in_c;
    logic [DATA_WIDTH-1:0] data_sh_c;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data     (i_data),
        .par_odd  (i_par_odd),
        .parity_c (parity_c)
    );

    // Prescale of zero behaves as one clock per bit
    assign reload_q_c  = (pre_q == '0) ? '0 : PRESCALE_W'(pre_q - PRESCALE_W'(1));
    assign reload_in_c = (i_prescale == '0) ? '0 : PRESCALE_W'(i_prescale - PRESCALE_W'(1));
    assign tick        = (cnt_q == '0);
    assign data_sh_c   = data_q >> idx_q;

    // Next-state, counters and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : PRESCALE_W'(cnt_q - PRESCALE_W'(1));
        idx_d   = idx_q;
        load    = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_data_valid) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    cnt_d   = reload_in_c;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d = ST_DATA;
                    cnt_d   = reload_q_c;
                end
            end
            ST_DATA: begin
                tx_d = data_sh_c[0];
                if (tick) begin
                    cnt_d = reload_q_c;
                    idx_d = IDX_W'(idx_q + IDX_W'(1));
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (tick) begin
                    state_d = ST_STOP1;
                    cnt_d   = reload_q_c;
                end
            end
            ST_STOP1: begin
                if (tick) begin
                    cnt_d = reload_q_c;
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, frame configuration and registered line outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            pre_q    <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) begin
                data_q   <= i_data;
                par_en_q <= i_par_en;
                par_q    <= parity_c;
                stop2_q  <= i_stop2;
                pre_q    <= i_prescale;
            end
            o_tx   <= tx_d;
            o_busy <= busy_d;
            o_done <= done_d;
        end
    end

endmodule
